// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM encoding and
// the command record carried through the FIFO.
package alu_pkg;

    localparam logic [3:0] OP_0 = 4'h0;
    localparam logic [3:0] OP_1 = 4'h1;
    localparam logic [3:0] OP_2 = 4'h2;
    localparam logic [3:0] OP_3 = 4'h3;
    localparam logic [3:0] OP_4 = 4'h4;
    localparam logic [3:0] OP_5 = 4'h5;
    localparam logic [3:0] OP_6 = 4'h6;
    localparam logic [3:0] OP_7 = 4'h7;
    localparam logic [3:0] OP_8 = 4'h8;
    localparam logic [3:0] OP_9 = 4'h9;
    localparam logic [3:0] OP_A = 4'hA;

    localparam logic [3:0] MAX_OP_DEF = OP_A;

    localparam int CMD_W = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; reads are combinational
// from the head entry so the sequencer can inspect the op before popping.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 8-bit ALU: buffers {op,a,b} commands, drives the ALU one
// command at a time, waits its fixed latency and returns the result downstream.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         ALU_LAT    = 1,
    parameter logic [3:0] MAX_OP     = MAX_OP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_select,
    input  logic [7:0] alu_final,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_op,
    output logic       res_err,
    output logic       busy
);

    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rdy_q;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0] alu_sel_q, alu_sel_d;
    logic       res_valid_q, res_valid_d;
    logic [7:0] res_data_q, res_data_d;
    logic [3:0] res_op_q, res_op_d;
    logic       res_err_q, res_err_d;

    logic         fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [CMD_W-1:0] fifo_rd;
    cmd_t         head;

    // rdy_q keeps cmd_ready low until the first clock after reset release.
    assign cmd_ready = rdy_q & ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;
    assign head      = cmd_t'(fifo_rd);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data ({cmd_op, cmd_a, cmd_b}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        res_err_d   = res_err_q;
        res_valid_d = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head.op <= MAX_OP) begin
                        alu_a_d   = head.a;
                        alu_b_d   = head.b;
                        alu_sel_d = head.op;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end else begin
                        // Illegal op bypasses the ALU; its inputs keep the last command.
                        res_data_d = '0;
                        res_op_d   = head.op;
                        res_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) state_d = CAPTURE;
                else                   cnt_d   = cnt_q + 3'd1;
            end
            CAPTURE: begin
                res_data_d = alu_final;
                res_op_d   = alu_sel_q;
                res_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                // Valid is registered, so it rises one edge after entering RESP.
                if (res_valid_q && res_ready) state_d     = IDLE;
                else                          res_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= 1'b1;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
            res_err_q   <= res_err_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_op     = res_op_q;
    assign res_err    = res_err_q;
    assign busy       = ~fifo_empty | (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencers (ALU latency 1 and 3) share stimulus; each
// drives an XOR ALU stub and is checked against a queue of expected results.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_op = '0;
    logic [7:0] cmd_a = '0, cmd_b = '0;
    logic       res_ready = 1'b0;

    logic       crdy1, crdy3, rv1, rv3, re1, re3, bz1, bz3;
    logic [7:0] aa1, ab1, aa3, ab3, fin1, fin3, rd1, rd3;
    logic [3:0] as1, as3, ro1, ro3;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(1), .MAX_OP(4'hA)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(crdy1),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(aa1), .alu_b(ab1), .alu_select(as1), .alu_final(fin1),
        .res_valid(rv1), .res_ready(res_ready), .res_data(rd1), .res_op(ro1),
        .res_err(re1), .busy(bz1));

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(3), .MAX_OP(4'hA)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(crdy3),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(aa3), .alu_b(ab3), .alu_select(as3), .alu_final(fin3),
        .res_valid(rv3), .res_ready(res_ready), .res_data(rd3), .res_op(ro3),
        .res_err(re3), .busy(bz3));

    // ALU stubs: a^b delayed by the matching number of register stages.
    logic [7:0] p3 [3];
    always @(posedge clk) fin1 <= aa1 ^ ab1;
    always @(posedge clk) begin
        p3[0] <= aa3 ^ ab3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign fin3 = p3[2];

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] op;
        logic       err;
    } exp_t;

    exp_t q1[$], q3[$];
    int total = 0, bad = 0, cyc = 0, push_cyc = 0;
    bit done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (op > 4'hA) e = '{d: 8'h00, op: op, err: 1'b1};
        else           e = '{d: a ^ b, op: op, err: 1'b0};
        return e;
    endfunction

    task automatic mon(input int id, input logic v, input logic [7:0] d,
                       input logic [3:0] op, input logic err);
        exp_t e;
        if (!v) return;
        if ((id == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_res dut%0d actual=%0h expected=none", id, {d, op, err});
            return;
        end
        e = (id == 1) ? q1[0] : q3[0];
        chk($sformatf("res dut%0d", id), {d, op, err}, e);
        if (res_ready) begin
            if (id == 1) void'(q1.pop_front());
            else         void'(q3.pop_front());
        end
    endtask

    // Monitor samples just after the falling edge, when bench drives have settled.
    always begin
        @(negedge clk);
        #1;
        mon(1, rv1, rd1, ro1, re1);
        mon(3, rv3, rd3, ro3, re3);
    end

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        while (!(crdy1 && crdy3) && t < 300) begin
            cmd_valid = 1'b0;
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            total++;
            bad++;
            $display("FAIL push_timeout actual=not_ready expected=ready");
            cmd_valid = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        q1.push_back(model(op, a, b));
        q3.push_back(model(op, a, b));
        @(posedge clk);
        #1 push_cyc = cyc;
    endtask

    task automatic wait_lat(input bit hold_chk, output int l1, output int l3);
        l1 = -1;
        l3 = -1;
        for (int t = 0; t < 30 && (l1 < 0 || l3 < 0); t++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rv1 && l1 < 0) l1 = cyc - push_cyc;
            if (rv3 && l3 < 0) l3 = cyc - push_cyc;
            if (hold_chk && l3 < 0 && (cyc - push_cyc) >= 1) begin
                chk("alu_a3 hold", aa3, 8'h10);
                chk("alu_b3 hold", ab3, 8'h01);
            end
        end
    endtask

    task automatic drain();
        bit ok = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = !bz1 && !bz3 && !rv1 && !rv3 && q1.size() == 0 && q3.size() == 0;
        end
        chk("drain", ok, 1'b1);
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, " dut1"}, {crdy1, rv1, aa1, ab1, as1, rd1, ro1, re1, bz1}, 64'h0);
        chk({nm, " dut3"}, {crdy3, rv3, aa3, ab3, as3, rd3, ro3, re3, bz3}, 64'h0);
    endtask

    int l1, l3;

    initial begin
        repeat (2) @(negedge clk);
        rst_chk("reset");
        rst = 1'b1;
        #1 chk("ready before clk", {crdy1, crdy3}, 2'b00);
        @(negedge clk);
        chk("ready after clk", {crdy1, crdy3}, 2'b11);

        // Basic latency and data.
        res_ready = 1'b1;
        push(4'h0, 8'h55, 8'hB5);
        wait_lat(1'b0, l1, l3);
        chk("lat1 legal", l1, 4);
        chk("lat3 legal", l3, 6);
        drain();

        // Longer ALU latency: inputs held through WAIT.
        push(4'h9, 8'h10, 8'h01);
        wait_lat(1'b1, l1, l3);
        chk("lat1 op9", l1, 4);
        chk("lat3 op9", l3, 6);
        drain();

        // Illegal op bypasses the ALU.
        push(4'hC, 8'h01, 8'h02);
        wait_lat(1'b0, l1, l3);
        chk("lat1 illegal", l1, 2);
        chk("lat3 illegal", l3, 2);
        chk("alu_select kept", {as1, as3}, 8'h99);
        chk("alu_a kept", {aa1, aa3}, 16'h1010);
        drain();

        // Fill the FIFO behind a stalled response.
        res_ready = 1'b0;
        push(4'h0, 8'h11, 8'h22);
        wait_lat(1'b0, l1, l3);
        push(4'h1, 8'hDB, 8'hAA);
        push(4'h2, 8'hDB, 8'hAA);
        push(4'h3, 8'h17, 8'hAA);
        push(4'h4, 8'h97, 8'hAA);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("full ready", {crdy1, crdy3}, 2'b00);
        chk("full busy", {bz1, bz3}, 2'b11);
        drain();

        // Long backpressure: response stable, next command not issued.
        res_ready = 1'b0;
        push(4'h5, 8'h33, 8'h0F);
        push(4'h6, 8'h44, 8'h0F);
        wait_lat(1'b0, l1, l3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold valid", {rv1, rv3}, 2'b11);
            chk("hold no issue", {aa1, aa3, as1, as3}, 24'h333355);
        end
        drain();

        // Reset while dut3 is in WAIT with two commands queued.
        res_ready = 1'b0;
        push(4'h1, 8'hA0, 8'h0A);
        push(4'h2, 8'hB0, 8'h0B);
        push(4'h3, 8'hC0, 8'h0C);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre-reset busy", {bz1, bz3}, 2'b11);
        rst = 1'b0;
        q1.delete();
        q3.delete();
        #1 rst_chk("mid reset");
        @(negedge clk);
        rst = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post-reset quiet", {rv1, rv3, bz1, bz3}, 4'b0000);
        end

        // Random traffic with random backpressure.
        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        cmd_valid = 1'b0;
                    end
                    push(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                end
                @(negedge clk);
                cmd_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
